// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: scrubs all registers after reset, then
// arbitrates the port round-robin between ALU (0), load (1) and mul/div (2).
module regfile_wb_arbiter #(
    parameter int unsigned        DATA_W  = 32,
    parameter int unsigned        ADDR_W  = 5,
    parameter int unsigned        SP_ADDR = 29,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(252)
) (
    input  logic              elk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_busy
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  scrub_cnt_q, scrub_cnt_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [2:0]         gnt_q, gnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               init_busy_q, init_busy_d;

    logic [2:0]         eligible;
    logic               win_valid;
    logic [1:0]         win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    // The requester granted last cycle is still holding req; mask it out.
    assign eligible  = req & ~gnt_q;
    assign win_valid = |eligible;

    always_comb begin
        win_idx = 2'd0;
        case (rr_ptr_q)
            2'd0:    win_idx = eligible[1] ? 2'd1 : (eligible[2] ? 2'd2 : 2'd0);
            2'd1:    win_idx = eligible[2] ? 2'd2 : (eligible[0] ? 2'd0 : 2'd1);
            default: win_idx = eligible[0] ? 2'd0 : (eligible[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        win_addr = req_addr0;
        win_data = req_data0;
        case (win_idx)
            2'd1:    begin win_addr = req_addr1; win_data = req_data1; end
            2'd2:    begin win_addr = req_addr2; win_data = req_data2; end
            default: begin win_addr = req_addr0; win_data = req_data0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        init_busy_d = init_busy_q;
        unique case (state_q)
            StInit: begin
                wr_en_d     = 1'b1;
                wr_addr_d   = scrub_cnt_q;
                wr_data_d   = (scrub_cnt_q == ADDR_W'(SP_ADDR)) ? SP_INIT : '0;
                scrub_cnt_d = scrub_cnt_q + 1'b1;
                if (scrub_cnt_q == '1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                init_busy_d = 1'b0;
                if (win_valid) begin
                    gnt_d     = 3'b001 << win_idx;
                    // r0 is hardwired zero: grant, but never write it.
                    wr_en_d   = (win_addr != '0);
                    wr_addr_d = win_addr;
                    wr_data_d = win_data;
                    rr_ptr_d  = win_idx;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge elk) begin
        if (rst) begin
            state_q     <= StInit;
            scrub_cnt_q <= '0;
            rr_ptr_q    <= 2'd2;
            gnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, scrub and
// reset sequences, and random traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        elk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [4:0]  req_addr0 = '0, req_addr1 = '0, req_addr2 = '0;
    logic [31:0] req_data0 = '0, req_data1 = '0, req_data2 = '0;
    logic [2:0]  gnt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_scrub = 0;
    bit          m_run   = 1'b0;
    logic [2:0]  m_gnt   = '0;
    logic        m_en    = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic        m_busy  = 1'b1;
    int          m_ptr   = 2;

    typedef struct {
        logic [2:0]  req;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  gnt;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    regfile_wb_arbiter dut (
        .elk       (elk),
        .rst       (rst),
        .req       (req),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_addr2 (req_addr2),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .gnt       (gnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_busy (init_busy)
    );

    always #5 elk = ~elk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [2:0] r, logic [4:0] a0, logic [31:0] d0,
                                logic [4:0] a1, logic [31:0] d1, logic [4:0] a2,
                                logic [31:0] d2, logic [2:0] g, logic e,
                                logic [4:0] ad, logic [31:0] da);
        vec_t v;
        v.req = r; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
        v.gnt = g; v.en = e; v.addr = ad; v.data = da;
        return v;
    endfunction

    // Round-robin: first eligible requester after the last winner.
    function automatic int pick(logic [2:0] elig, int ptr);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (ptr + k) % 3;
            if (elig[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        logic [4:0]  addrs[3];
        logic [31:0] datas[3];
        int w;
        addrs[0] = req_addr0; addrs[1] = req_addr1; addrs[2] = req_addr2;
        datas[0] = req_data0; datas[1] = req_data1; datas[2] = req_data2;
        if (rst) begin
            m_scrub = 0; m_run = 1'b0; m_gnt = '0; m_en = 1'b0;
            m_addr = '0; m_data = '0; m_busy = 1'b1; m_ptr = 2;
        end else if (!m_run) begin
            m_gnt  = '0;
            m_en   = 1'b1;
            m_addr = 5'(m_scrub);
            m_data = (m_scrub == 29) ? 32'd252 : 32'd0;
            m_scrub++;
            if (m_scrub == 32) m_run = 1'b1;
        end else begin
            m_busy = 1'b0;
            w = pick(req & ~m_gnt, m_ptr);
            if (w < 0) begin
                m_gnt = '0;
                m_en  = 1'b0;
            end else begin
                m_gnt  = 3'b001 << w;
                m_addr = addrs[w];
                m_data = datas[w];
                m_en   = (addrs[w] != 5'd0);
                m_ptr  = w;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model_gnt", 32'(gnt), 32'(m_gnt));
        chk("model_wr_en", 32'(wr_en), 32'(m_en));
        chk("model_wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("model_wr_data", wr_data, m_data);
        chk("model_init_busy", 32'(init_busy), 32'(m_busy));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("gnt_in_init", 32'(init_busy && (gnt != 3'b000)), 32'd0);
    endtask

    task automatic step();
        @(posedge elk);
        model_update();
        #1;
        check_model();
    endtask

    initial begin
        bit seen17;

        // Scrub with all requesters holding throughout reset and INIT.
        #1;
        rst = 1'b1; req = 3'b111;
        step(); step();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        chk("reset_busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("scrub_wr_en", 32'(wr_en), 32'd1);
            chk("scrub_addr", 32'(wr_addr), 32'(i));
            chk("scrub_data", wr_data, (i == 29) ? 32'd252 : 32'd0);
            chk("scrub_gnt", 32'(gnt), 32'd0);
            chk("scrub_busy", 32'(init_busy), 32'd1);
        end
        step();
        chk("busy_fall_c33", 32'(init_busy), 32'd0);
        chk("first_run_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        step(); step();

        // Directed table: single request, r0 suppression, contention.
        vecs.push_back(mk(3'b001, 5, 32'hDEADBEEF, 2, 32'h20, 3, 32'h30, 3'b001, 1, 5, 32'hDEADBEEF));
        vecs.push_back(mk(3'b001, 5, 32'hDEADBEEF, 2, 32'h20, 3, 32'h30, 3'b000, 0, 5, 32'hDEADBEEF));
        vecs.push_back(mk(3'b000, 5, 32'hDEADBEEF, 2, 32'h20, 3, 32'h30, 3'b000, 0, 5, 32'hDEADBEEF));
        vecs.push_back(mk(3'b010, 1, 32'h10, 0, 32'h1234, 3, 32'h30, 3'b010, 0, 0, 32'h1234));
        vecs.push_back(mk(3'b010, 1, 32'h10, 0, 32'h1234, 3, 32'h30, 3'b000, 0, 0, 32'h1234));
        vecs.push_back(mk(3'b000, 1, 32'h10, 0, 32'h1234, 3, 32'h30, 3'b000, 0, 0, 32'h1234));
        vecs.push_back(mk(3'b111, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b100, 1, 3, 32'h30));
        vecs.push_back(mk(3'b111, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b001, 1, 1, 32'h10));
        vecs.push_back(mk(3'b011, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b010, 1, 2, 32'h20));
        vecs.push_back(mk(3'b110, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b100, 1, 3, 32'h30));
        vecs.push_back(mk(3'b101, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b001, 1, 1, 32'h10));
        vecs.push_back(mk(3'b011, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b010, 1, 2, 32'h20));
        vecs.push_back(mk(3'b000, 1, 32'h10, 2, 32'h20, 3, 32'h30, 3'b000, 0, 2, 32'h20));
        foreach (vecs[i]) begin
            req = vecs[i].req;
            req_addr0 = vecs[i].a0; req_addr1 = vecs[i].a1; req_addr2 = vecs[i].a2;
            req_data0 = vecs[i].d0; req_data1 = vecs[i].d1; req_data2 = vecs[i].d2;
            step();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].data);
        end

        // Reset in the middle of a scrub, once address 17 is being written.
        rst = 1'b1; step(); rst = 1'b0;
        seen17 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (init_busy && wr_addr == 5'd17) begin
                seen17 = 1'b1;
                break;
            end
        end
        chk("reach_addr17", 32'(seen17), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", wr_data, 32'd0);
        chk("midrst_busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("rescrub_addr", 32'(wr_addr), 32'(i));
            chk("rescrub_wr_en", 32'(wr_en), 32'd1);
        end
        step();
        chk("rescrub_busy_fall", 32'(init_busy), 32'd0);

        // One requester holding continuously: granted every other cycle.
        req = 3'b100; req_addr2 = 5'd7; req_data2 = 32'hCAFE0007;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("b2b_gnt", 32'(gnt), (k % 2 == 0) ? 32'b100 : 32'b000);
        end
        req = 3'b000;
        step();

        // Random traffic with occasional resets, checked against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 127) == 0);
            req = 3'($urandom);
            req_addr0 = 5'($urandom); req_addr1 = 5'($urandom); req_addr2 = 5'($urandom);
            req_data0 = $urandom; req_data1 = $urandom; req_data2 = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
